aes_v3_serial: RTL and testbench

Parametrised successor to the single-cycle AES Sub/Mix functional unit. It computes the same two ops from rs1/rs2:
- SubBytes/InvSubBytes, byte-interleaved.
- MixColumn/InvMixColumn.
Work is time-multiplexed over a configurable number of S-box and mix-byte lanes, trading latency for area. It sits in the core's execute stage behind a multi-cycle valid/ready handshake. Results are registered and rd is zeroed unless ready, so no partial results leak.

---
 rtl/aes_v3_serial_pkg.sv | 64 ++++++
 rtl/aes_v3_serial_if.sv | 19 +
 rtl/aes_v3_serial_mix_byte.sv | 23 ++
 rtl/aes_v3_serial.sv | 154 +++++++++++++++
 tb/tb_aes_v3_serial.sv | 246 ++++++++++++++++++++++++
 5 files changed

// File: rtl/aes_v3_serial_pkg.sv
// aes_v3_serial_pkg
// Shared types and GF(2^8) helpers for the serial AES Sub/Mix unit.
//   state_e      : FSM encoding (IDLE / BUSY / DONE), also used as debug output
//   xt2, gf_mul  : GF(2^8) doubling and general multiply, reduction poly 0x1b
//   aes_sbox     : forward (enc=1) or inverse (enc=0) AES S-box, one byte
//   MIX_*        : MixColumn coefficient constants for encrypt/decrypt
package aes_v3_serial_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam logic [7:0] MIX_ENC_A = 8'h02;
    localparam logic [7:0] MIX_ENC_B = 8'h03;
    localparam logic [7:0] MIX_DEC_A = 8'h0e;
    localparam logic [7:0] MIX_DEC_B = 8'h0b;
    localparam logic [7:0] MIX_DEC_C = 8'h0d;
    localparam logic [7:0] MIX_DEC_D = 8'h09;

    function automatic logic [7:0] xt2(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xt2(x);
        end
        return p;
    endfunction

    // Multiplicative inverse as x^254 (= x^2 * x^4 * ... * x^128); maps 0 to 0.
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] sq;
        logic [7:0] r;
        sq = x;
        r  = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq = gf_mul(sq, sq);
            r  = gf_mul(r, sq);
        end
        return r;
    endfunction

    function automatic logic [7:0] affine_fwd(input logic [7:0] x);
        return x ^ {x[6:0], x[7]} ^ {x[5:0], x[7:6]} ^ {x[4:0], x[7:5]}
                 ^ {x[3:0], x[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [7:0] affine_inv(input logic [7:0] x);
        return {x[6:0], x[7]} ^ {x[4:0], x[7:5]} ^ {x[1:0], x[7:2]} ^ 8'h05;
    endfunction

    function automatic logic [7:0] aes_sbox(input logic [7:0] x, input logic enc);
        return enc ? affine_fwd(gf_inv(x)) : gf_inv(affine_inv(x));
    endfunction

endpackage

// File: rtl/aes_v3_serial_if.sv
// aes_v3_serial_if
// Execute-stage request/response bundle for the serial AES unit.
//   valid, sub, enc, rs1, rs2 : request from the core (master drives)
//   ready, rd                 : completion from the unit (slave drives)
// Handshake: the master raises valid and holds sub/enc/rs1/rs2 stable until
// it samples ready=1; ready is a single-cycle pulse and rd is non-zero only
// in that cycle. A transfer completes in the cycle where valid && ready.
interface aes_v3_serial_if;
    logic        valid;
    logic        sub;
    logic        enc;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic        ready;
    logic [31:0] rd;

    modport master (output valid, sub, enc, rs1, rs2, input ready, rd);
    modport slave  (input valid, sub, enc, rs1, rs2, output ready, rd);
endinterface

// File: rtl/aes_v3_serial_mix_byte.sv
// aes_v3_serial_mix_byte
// One output byte of MixColumn (enc=1) or InvMixColumn (enc=0).
//   a, b, c, d : column bytes m[j], m[j+1], m[j+2], m[j+3]
//   enc        : 1 = forward, 0 = inverse
//   y          : result byte j
module aes_v3_serial_mix_byte
    import aes_v3_serial_pkg::*;
(
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic [7:0] c,
    input  logic [7:0] d,
    input  logic       enc,
    output logic [7:0] y
);
    logic [7:0] y_enc;
    logic [7:0] y_dec;

    assign y_enc = gf_mul(a, MIX_ENC_A) ^ gf_mul(b, MIX_ENC_B) ^ c ^ d;
    assign y_dec = gf_mul(a, MIX_DEC_A) ^ gf_mul(b, MIX_DEC_B)
                 ^ gf_mul(c, MIX_DEC_C) ^ gf_mul(d, MIX_DEC_D);
    assign y     = enc ? y_enc : y_dec;
endmodule

// File: rtl/aes_v3_serial.sv
// aes_v3_serial
// Time-multiplexed AES SubBytes/MixColumn unit. Each op is split into
// 4/LANES chunks; chunk k writes bytes k*L .. k*L+L-1 of the result register.
//   g_clk, g_reset : clock, synchronous active-high reset
//   bus            : request/response bundle (slave side)
//   fsm_state      : current FSM state, for observation only
module aes_v3_serial
    import aes_v3_serial_pkg::*;
#(
    parameter int SBOX_LANES = 4,
    parameter int MIX_LANES  = 4
) (
    input  logic          g_clk,
    input  logic          g_reset,
    aes_v3_serial_if.slave bus,
    output state_e        fsm_state
);
    localparam int NS = 4 / SBOX_LANES;
    localparam int NM = 4 / MIX_LANES;

    if (!(SBOX_LANES == 1 || SBOX_LANES == 2 || SBOX_LANES == 4)) begin : g_bad_sbox
        $error("aes_v3_serial: SBOX_LANES must be 1, 2 or 4");
    end
    if (!(MIX_LANES == 1 || MIX_LANES == 2 || MIX_LANES == 4)) begin : g_bad_mix
        $error("aes_v3_serial: MIX_LANES must be 1, 2 or 4");
    end

    state_e      state;
    state_e      state_nxt;
    logic [1:0]  count;
    logic        sub_q;
    logic        enc_q;
    logic [31:0] result;
    logic [31:0] result_nxt;
    logic        ready_q;

    logic        sub_m;
    logic        enc_m;
    logic [1:0]  chunk;
    logic [1:0]  last;
    logic        load;

    logic [7:0]  sub_src [4];
    logic [7:0]  mix_in  [4];
    logic [7:0]  sbox_out [SBOX_LANES];
    logic [7:0]  mix_out  [MIX_LANES];
    logic        unused_bits;

    // State register
    always_ff @(posedge g_clk) begin
        if (g_reset) state <= ST_IDLE;
        else         state <= state_nxt;
    end

    // Next-state logic; dropping valid in BUSY aborts the op.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (bus.valid) state_nxt = (chunk == last) ? ST_DONE : ST_BUSY;
            ST_BUSY: begin
                if (!bus.valid)         state_nxt = ST_IDLE;
                else if (chunk == last) state_nxt = ST_DONE;
            end
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Output/control decode. In IDLE the incoming mode is used directly
    // because it is only being latched at the end of this cycle.
    always_comb begin
        sub_m = sub_q;
        enc_m = enc_q;
        chunk = count;
        load  = 1'b0;
        case (state)
            ST_IDLE: begin
                sub_m = bus.sub;
                enc_m = bus.enc;
                chunk = 2'd0;
                load  = bus.valid;
            end
            ST_BUSY: load = bus.valid;
            default: load = 1'b0;
        endcase
        last = sub_m ? 2'(NS - 1) : 2'(NM - 1);
    end

    // Datapath registers
    always_ff @(posedge g_clk) begin
        if (g_reset) begin
            count   <= 2'd0;
            sub_q   <= 1'b0;
            enc_q   <= 1'b0;
            result  <= 32'h0;
            ready_q <= 1'b0;
        end else begin
            ready_q <= (state_nxt == ST_DONE);
            count   <= (state_nxt == ST_BUSY) ? chunk + 2'd1 : 2'd0;
            if (state == ST_IDLE && bus.valid) begin
                sub_q <= bus.sub;
                enc_q <= bus.enc;
            end
            if (load) result <= result_nxt;
        end
    end

    // Byte sources; rs1/rs2 are read live every cycle.
    assign sub_src[0] = bus.rs1[7:0];
    assign sub_src[1] = bus.rs2[15:8];
    assign sub_src[2] = bus.rs1[23:16];
    assign sub_src[3] = bus.rs2[31:24];
    assign mix_in[0]  = bus.rs1[7:0];
    assign mix_in[1]  = bus.rs1[15:8];
    assign mix_in[2]  = bus.rs2[23:16];
    assign mix_in[3]  = bus.rs2[31:24];
    assign unused_bits = ^{bus.rs1[31:24], bus.rs2[7:0]};

    for (genvar l = 0; l < SBOX_LANES; l++) begin : g_sbox
        logic [1:0] idx;
        assign idx         = 2'(int'(chunk) * SBOX_LANES + l);
        assign sbox_out[l] = aes_sbox(sub_src[idx], enc_m);
    end

    // Lane l of chunk k produces byte j = k*MIX_LANES + l; 2-bit index wraps mod 4.
    for (genvar l = 0; l < MIX_LANES; l++) begin : g_mix
        logic [1:0] j0;
        assign j0 = 2'(int'(chunk) * MIX_LANES + l);
        aes_v3_serial_mix_byte u_mix (
            .a   (mix_in[j0]),
            .b   (mix_in[j0 + 2'd1]),
            .c   (mix_in[j0 + 2'd2]),
            .d   (mix_in[j0 + 2'd3]),
            .enc (enc_m),
            .y   (mix_out[l])
        );
    end

    // Only bytes belonging to the current chunk are replaced.
    always_comb begin
        result_nxt = result;
        for (int j = 0; j < 4; j++) begin
            if (sub_m) begin
                if (2'(j / SBOX_LANES) == chunk) result_nxt[8*j +: 8] = sbox_out[j % SBOX_LANES];
            end else begin
                if (2'(j / MIX_LANES) == chunk) result_nxt[8*j +: 8] = mix_out[j % MIX_LANES];
            end
        end
    end

    assign bus.ready = ready_q;
    assign bus.rd    = ready_q ? result : 32'h0;
    assign fsm_state = state;
endmodule

// File: tb/tb_aes_v3_serial.sv
module tb_aes_v3_serial;
    import aes_v3_serial_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // Three instances: index 0 = 4 lanes, 1 = 1 lane, 2 = 2 lanes.
    aes_v3_serial_if i4 ();
    aes_v3_serial_if i1 ();
    aes_v3_serial_if i2 ();

    logic        vld   [3];
    logic        o_sub [3];
    logic        o_enc [3];
    logic [31:0] o_rs1 [3];
    logic [31:0] o_rs2 [3];
    logic        rdy   [3];
    logic [31:0] rdv   [3];
    state_e      stv   [3];
    state_e      st4, st1, st2;

    assign i4.valid = vld[0]; assign i4.sub = o_sub[0]; assign i4.enc = o_enc[0];
    assign i4.rs1 = o_rs1[0]; assign i4.rs2 = o_rs2[0];
    assign i1.valid = vld[1]; assign i1.sub = o_sub[1]; assign i1.enc = o_enc[1];
    assign i1.rs1 = o_rs1[1]; assign i1.rs2 = o_rs2[1];
    assign i2.valid = vld[2]; assign i2.sub = o_sub[2]; assign i2.enc = o_enc[2];
    assign i2.rs1 = o_rs1[2]; assign i2.rs2 = o_rs2[2];
    assign rdy[0] = i4.ready; assign rdv[0] = i4.rd; assign stv[0] = st4;
    assign rdy[1] = i1.ready; assign rdv[1] = i1.rd; assign stv[1] = st1;
    assign rdy[2] = i2.ready; assign rdv[2] = i2.rd; assign stv[2] = st2;

    aes_v3_serial #(.SBOX_LANES(4), .MIX_LANES(4)) d4 (
        .g_clk(clk), .g_reset(rst), .bus(i4.slave), .fsm_state(st4));
    aes_v3_serial #(.SBOX_LANES(1), .MIX_LANES(1)) d1 (
        .g_clk(clk), .g_reset(rst), .bus(i1.slave), .fsm_state(st1));
    aes_v3_serial #(.SBOX_LANES(2), .MIX_LANES(2)) d2 (
        .g_clk(clk), .g_reset(rst), .bus(i2.slave), .fsm_state(st2));

    int total = 0;
    int bad   = 0;
    int lat [3] = '{1, 4, 2};

    task automatic set_op(input int d, input logic s, input logic e,
                          input logic [31:0] a, input logic [31:0] b);
        o_sub[d] = s; o_enc[d] = e; o_rs1[d] = a; o_rs2[d] = b;
    endtask

    task automatic test_reset();
        for (int d = 0; d < 3; d++) begin
            vld[d] = 1'b0;
            set_op(d, 1'b0, 1'b0, 32'h0, 32'h0);
        end
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < 3; d++) begin
            total++;
            if (rdy[d] !== 1'b0) begin bad++; $display("FAIL reset_ready dut%0d: got %b want 0", d, rdy[d]); end
            total++;
            if (rdv[d] !== 32'h0) begin bad++; $display("FAIL reset_rd dut%0d: got %h want 0", d, rdv[d]); end
            total++;
            if (stv[d] !== ST_IDLE) begin bad++; $display("FAIL reset_state dut%0d: got %0d want %0d", d, stv[d], ST_IDLE); end
        end
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    // Issues one op on all three instances; each drops valid on its own ready.
    task automatic run_op(input string name, input logic s, input logic e,
                          input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp_rd);
        int seen [3];
        int pulses [3];
        bit leak [3];
        for (int d = 0; d < 3; d++) begin
            set_op(d, s, e, a, b);
            vld[d] = 1'b1;
            seen[d] = -1; pulses[d] = 0; leak[d] = 1'b0;
        end
        for (int c = 1; c <= 10; c++) begin
            @(posedge clk);
            #1;
            for (int d = 0; d < 3; d++) begin
                if (rdy[d] === 1'b1) begin
                    pulses[d]++;
                    if (pulses[d] == 1) begin
                        seen[d] = c;
                        total++;
                        if (rdv[d] !== exp_rd) begin
                            bad++; $display("FAIL %s_rd dut%0d: got %h want %h", name, d, rdv[d], exp_rd);
                        end
                        vld[d] = 1'b0;
                    end
                end else if (rdv[d] !== 32'h0) begin
                    leak[d] = 1'b1;
                end
            end
        end
        for (int d = 0; d < 3; d++) begin
            total++;
            if (seen[d] != lat[d]) begin
                bad++; $display("FAIL %s_latency dut%0d: got %0d want %0d", name, d, seen[d], lat[d]);
            end
            total++;
            if (pulses[d] != 1 || leak[d]) begin
                bad++; $display("FAIL %s_pulse dut%0d: pulses %0d leak %0d want 1/0", name, d, pulses[d], leak[d]);
            end
        end
    endtask

    task automatic test_sub_enc();
        run_op("sub_enc", 1'b1, 1'b1, 32'h00530000, 32'h63000100, 32'hfbed7c63);
        run_op("sub_enc_ff", 1'b1, 1'b1, 32'h00ff00ff, 32'hff00ff00, 32'h16161616);
    endtask

    task automatic test_sub_dec();
        run_op("sub_dec", 1'b1, 1'b0, 32'h00ed0063, 32'hfb007c00, 32'h63530100);
    endtask

    task automatic test_mix_enc();
        run_op("mix_enc", 1'b0, 1'b1, 32'h000013db, 32'h45530000, 32'hbca14d8e);
        run_op("mix_enc_f2", 1'b0, 1'b1, 32'h00000af2, 32'h5c220000, 32'h9d58dc9f);
    endtask

    task automatic test_mix_dec();
        run_op("mix_dec", 1'b0, 1'b0, 32'h00004d8e, 32'hbca10000, 32'h455313db);
    endtask

    // Single-lane instance: drop valid on the last BUSY cycle.
    task automatic test_abort();
        bit fired;
        set_op(1, 1'b1, 1'b1, 32'h00530000, 32'h63000100);
        vld[1] = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (stv[1] !== ST_BUSY) begin bad++; $display("FAIL abort_busy: got %0d want %0d", stv[1], ST_BUSY); end
        vld[1] = 1'b0;
        @(posedge clk);
        #1;
        total++;
        if (stv[1] !== ST_IDLE) begin bad++; $display("FAIL abort_state: got %0d want %0d", stv[1], ST_IDLE); end
        total++;
        if (rdy[1] !== 1'b0 || rdv[1] !== 32'h0) begin
            bad++; $display("FAIL abort_out: got ready %b rd %h want 0/0", rdy[1], rdv[1]);
        end
        fired = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            if (rdy[1] !== 1'b0 || rdv[1] !== 32'h0) fired = 1'b1;
        end
        total++;
        if (fired) begin bad++; $display("FAIL abort_quiet: got late output want none"); end
        run_op("after_abort", 1'b0, 1'b0, 32'h00004d8e, 32'hbca10000, 32'h455313db);
    endtask

    // Reset on the cycle that would otherwise enter DONE.
    task automatic test_reset_busy();
        bit fired;
        set_op(1, 1'b1, 1'b1, 32'h00530000, 32'h63000100);
        vld[1] = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        total++;
        if (rdy[1] !== 1'b0) begin bad++; $display("FAIL rstbusy_ready: got %b want 0", rdy[1]); end
        total++;
        if (rdv[1] !== 32'h0) begin bad++; $display("FAIL rstbusy_rd: got %h want 0", rdv[1]); end
        total++;
        if (stv[1] !== ST_IDLE) begin bad++; $display("FAIL rstbusy_state: got %0d want %0d", stv[1], ST_IDLE); end
        rst = 1'b0;
        vld[1] = 1'b0;
        fired = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk);
            #1;
            if (rdy[1] !== 1'b0) fired = 1'b1;
        end
        total++;
        if (fired) begin bad++; $display("FAIL rstbusy_quiet: got ready pulse want none"); end
        run_op("after_reset", 1'b1, 1'b1, 32'h00530000, 32'h63000100, 32'hfbed7c63);
    endtask

    // Valid held high across two ops; second operands appear the cycle after ready.
    task automatic test_back_to_back();
        int t1 [3];
        int t2 [3];
        int p [3];
        for (int d = 0; d < 3; d++) begin
            set_op(d, 1'b0, 1'b1, 32'h000013db, 32'h45530000);
            vld[d] = 1'b1;
            t1[d] = -1; t2[d] = -1; p[d] = 0;
        end
        for (int c = 1; c <= 16; c++) begin
            @(posedge clk);
            #1;
            for (int d = 0; d < 3; d++) begin
                if (rdy[d] === 1'b1) begin
                    p[d]++;
                    if (p[d] == 1) begin
                        t1[d] = c;
                        total++;
                        if (rdv[d] !== 32'hbca14d8e) begin
                            bad++; $display("FAIL b2b_rd1 dut%0d: got %h want bca14d8e", d, rdv[d]);
                        end
                    end else if (p[d] == 2) begin
                        t2[d] = c;
                        total++;
                        if (rdv[d] !== 32'h63530100) begin
                            bad++; $display("FAIL b2b_rd2 dut%0d: got %h want 63530100", d, rdv[d]);
                        end
                        vld[d] = 1'b0;
                    end
                end
                if (p[d] == 1 && c == t1[d] + 1) set_op(d, 1'b1, 1'b0, 32'h00ed0063, 32'hfb007c00);
            end
        end
        for (int d = 0; d < 3; d++) begin
            total++;
            if (t1[d] != lat[d]) begin
                bad++; $display("FAIL b2b_first dut%0d: got %0d want %0d", d, t1[d], lat[d]);
            end
            total++;
            if (t2[d] - t1[d] != lat[d] + 1 || p[d] != 2) begin
                bad++; $display("FAIL b2b_gap dut%0d: got gap %0d pulses %0d want %0d/2", d, t2[d] - t1[d], p[d], lat[d] + 1);
            end
        end
    endtask

    initial begin
        test_reset();
        test_sub_enc();
        test_sub_dec();
        test_mix_enc();
        test_mix_dec();
        test_abort();
        test_reset_busy();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
